aes_key_schedule_seq: RTL and testbench
=======================================

// Module: aes_key_schedule_seq
// PURPOSE
// - Sequential AES key schedule for AES-128/192/256, selected per run by key_len.
// - Expands the cipher key one 32-bit word per cycle into an internal word array.
// - Round key i (i = 0..Nr) is read combinationally from that array by index.
// - Feeds iterative AES round cores that need any key size, or on-the-fly re-keying.
// PARAMETERS
// - MAX_KEY_BITS  256  largest key length supported (128/192/256).
//   Array depth NW = 4*(Nr_max+1), i.e. 44/52/60 words.
// - RK_IDX_W      4    width of the round-key read index.
// PORTS
// - clk        in   1    single clock; all state updates on rising edge
// - rst_n      in   1    synchronous, active-low reset
// - start      in   1    request expansion; accepted only when busy=0
// - key_len    in   2    00=AES-128, 01=AES-192, 10=AES-256, 11=illegal
// - key_in     in   256  key, MSB-aligned; word0 = key_in[255:224]; unused LSBs ignored
// - busy       out  1    expansion in progress
// - done       out  1    one-cycle pulse; last word written
// - keys_valid out  1    array holds a complete schedule for cur_len
// - err        out  1    one-cycle pulse; start seen with key_len=11 or key_len > MAX_KEY_BITS
// - rk_idx     in   RK_IDX_W  round-key select
// - rk_data    out  128  {w[4i],w[4i+1],w[4i+2],w[4i+3]}; 0 if rk_idx > Nr(cur_len)
// BEHAVIOUR
// - Reset: busy=0, done=0, err=0, keys_valid=0; word array cleared (so rk_data=0); cur_len=00.
// - Nk/Nr: 128->4/10, 192->6/12, 256->8/14. Generated words: N = 4*(Nr+1)-Nk = 40/46/52.
// - Accepting start (start=1 & busy=0 & legal):
//   - load w[0..Nk-1] from key_in; latch cur_len.
//   - busy<=1, keys_valid<=0.
//   - rcon<=8'h01, phase counter j<=0, write ptr i<=Nk.
// - Illegal start: nothing changes except err=1 for one cycle; the old schedule stays valid.
// - start while busy=1: ignored, no err.
// - Each busy cycle writes w[i] = w[i-Nk] ^ temp, where:
//   - j==0: temp = SubWord(RotWord(w[i-1])) ^ {rcon,24'h0}; then rcon = xtime(rcon) (0x80 -> 0x1B).
//   - Nk==8 & j==4: temp = SubWord(w[i-1]).
//   - otherwise: temp = w[i-1].
//   - j wraps Nk-1 -> 0. No divide or modulo hardware.
// - Latency: start sampled at edge E0. Words are written at E1..EN.
//   At EN: busy<=0, done<=1, keys_valid<=1.
//   done is high during the cycle N+1 after the start cycle (41/47/53).
// - done and busy=0 coincide, so a start in the done cycle is accepted; done still ends after one cycle.
// - rk_data is combinational from the array and cur_len. While busy it shows partial or stale
//   contents; consumers gate on keys_valid. Array words above 4*(Nr+1)-1 are never read.
// - rst_n low mid-run aborts: full reset state next edge; no done pulse.
// STRUCTURE
// - aes_pkg: key_len encodings; Nk/Nr/N lookup constants; xtime function; AES S-box table function.
// - Sub-module aes_sub_word: 32-bit combinational SubWord (4 S-box lookups).
//   Single instance, shared between the RotWord and plain-SubWord paths via an input mux.
// - Top level: control FSM IDLE -> RUN -> IDLE (done pulses on the RUN->IDLE edge);
//   word array with one write port; rcon register; j and i counters.
// TESTING
// - AES-128, key 2b7e151628aed2a6abf7158809cf4f3c:
//   done 41 cycles after start; rk_idx=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6;
//   rk_idx=1 -> a0fafe1788542cb123a339392a6c7605.
// - AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
//   done at cycle 47; rk_idx=12 low word w[51]=01002202; rk_idx=13 -> 0.
// - AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
//   done at cycle 53; w[59]=706c631e; checks the j==4 SubWord path.
// - Illegal and ignored starts:
//   - key_len=11 start after a valid 128 run -> err pulse, keys_valid stays 1, rk_data unchanged.
//   - start during busy -> ignored, done timing unchanged.
// - Reset at cycle 20 of a 256 run -> busy=0, keys_valid=0, rk_data=0, no done.
//   A following 128 start completes correctly.
// - Back-to-back: new start asserted in the done cycle -> busy stays 1 next cycle,
//   second done after the correct latency; outputs match the golden model.

Source files
------------

// File: rtl/aes_key_schedule_seq_pkg.sv
// Shared definitions for the sequential AES key schedule: key-length
// encodings, FSM states, Nk/Nr/word-count lookups, xtime and the S-box.
package aes_key_schedule_seq_pkg;

  typedef enum logic [1:0] {
    KEY_128 = 2'b00,
    KEY_192 = 2'b01,
    KEY_256 = 2'b10,
    KEY_ILL = 2'b11
  } key_len_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Key length in 32-bit words.
  function automatic logic [3:0] nk_of(input key_len_e len);
    case (len)
      KEY_128: return 4'd4;
      KEY_192: return 4'd6;
      default: return 4'd8;
    endcase
  endfunction

  // Number of rounds.
  function automatic logic [3:0] nr_of(input key_len_e len);
    case (len)
      KEY_128: return 4'd10;
      KEY_192: return 4'd12;
      default: return 4'd14;
    endcase
  endfunction

  // Total schedule words, 4*(Nr+1).
  function automatic logic [5:0] words_of(input key_len_e len);
    case (len)
      KEY_128: return 6'd44;
      KEY_192: return 6'd52;
      default: return 6'd60;
    endcase
  endfunction

  function automatic int key_bits_of(input key_len_e len);
    return 128 + 64 * int'(len);
  endfunction

  // Multiply by x in GF(2^8), reduction polynomial 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[8*(255 - int'(b)) +: 8];
  endfunction

endpackage

// File: rtl/aes_key_schedule_seq_if.sv
// Request / status / round-key read bundle of the key schedule.
interface aes_key_schedule_seq_if #(
  parameter int RK_IDX_W = 4
);
  logic                start;
  logic [1:0]          key_len;
  logic [255:0]        key_in;
  logic                busy;
  logic                done;
  logic                keys_valid;
  logic                err;
  logic [RK_IDX_W-1:0] rk_idx;
  logic [127:0]        rk_data;

  modport master (
    output start, key_len, key_in, rk_idx,
    input  busy, done, keys_valid, err, rk_data
  );

  modport slave (
    input  start, key_len, key_in, rk_idx,
    output busy, done, keys_valid, err, rk_data
  );
endinterface

// File: rtl/aes_key_schedule_seq_sub_word.sv
// Combinational SubWord: four parallel S-box lookups on a 32-bit word.
module aes_key_schedule_seq_sub_word
  import aes_key_schedule_seq_pkg::*;
(
  input  logic [31:0] din,
  output logic [31:0] dout
);

  assign dout = {sbox(din[31:24]), sbox(din[23:16]), sbox(din[15:8]), sbox(din[7:0])};

endmodule

// File: rtl/aes_key_schedule_seq.sv
// Sequential AES-128/192/256 key schedule: one expanded word per cycle into a
// word array, round keys read combinationally by index.
module aes_key_schedule_seq
  import aes_key_schedule_seq_pkg::*;
#(
  parameter int MAX_KEY_BITS = 256,
  parameter int RK_IDX_W     = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  aes_key_schedule_seq_if.slave bus
);

  localparam int NR_MAX = MAX_KEY_BITS / 32 + 6;
  localparam int NW     = 4 * (NR_MAX + 1);
  localparam int PTR_W  = $clog2(NW);

  state_e              state;
  state_e              state_nxt;
  key_len_e            cur_len;
  key_len_e            req_len;
  logic [31:0]         w [NW];
  logic [7:0]          rcon;
  logic [2:0]          j;
  logic [PTR_W-1:0]    wr_ptr;
  logic                req_legal;
  logic                accept;
  logic                reject;
  logic                run_en;
  logic                last;
  logic                done_q;
  logic                err_q;
  logic                valid_q;
  logic [3:0]          nk_cur;
  logic [31:0]         prev_word;
  logic [31:0]         back_word;
  logic [31:0]         sub_in;
  logic [31:0]         sub_out;
  logic [31:0]         temp;
  logic [31:0]         new_word;
  logic [RK_IDX_W-1:0] idx;
  logic [PTR_W-1:0]    base;

  assign req_len   = key_len_e'(bus.key_len);
  assign req_legal = (req_len != KEY_ILL) && (key_bits_of(req_len) <= MAX_KEY_BITS);
  assign nk_cur    = nk_of(cur_len);
  assign last      = (wr_ptr == PTR_W'(words_of(cur_len) - 6'd1));

  assign prev_word = w[wr_ptr - PTR_W'(1)];
  assign back_word = w[wr_ptr - PTR_W'(nk_cur)];

  // One S-box bank serves both the RotWord path (j==0) and the AES-256 mid-key path.
  assign sub_in = (j == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;

  aes_key_schedule_seq_sub_word u_sub_word (
    .din  (sub_in),
    .dout (sub_out)
  );

  // Select the temp word mixed into w[i-Nk] according to the phase j.
  always_comb begin
    temp = prev_word;
    if (j == 3'd0) begin
      temp = sub_out ^ {rcon, 24'h0};
    end else if ((nk_cur == 4'd8) && (j == 3'd4)) begin
      temp = sub_out;
    end
  end

  assign new_word = back_word ^ temp;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // FSM next state: run until the last schedule word is written.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.start && req_legal) state_nxt = ST_RUN;
      ST_RUN:  if (last)                   state_nxt = ST_IDLE;
      default:                             state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: decoded strobes for start handling and expansion.
  always_comb begin
    accept = 1'b0;
    reject = 1'b0;
    run_en = 1'b0;
    case (state)
      ST_IDLE: begin
        accept = bus.start && req_legal;
        reject = bus.start && !req_legal;
      end
      ST_RUN:  run_en = 1'b1;
      default: ;
    endcase
  end

  // Status pulses, active length, rcon and the j / write-pointer counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      cur_len <= KEY_128;
      rcon    <= 8'h01;
      j       <= 3'd0;
      wr_ptr  <= '0;
    end else begin
      done_q <= run_en && last;
      err_q  <= reject;
      if (accept) begin
        cur_len <= req_len;
        valid_q <= 1'b0;
        rcon    <= 8'h01;
        j       <= 3'd0;
        wr_ptr  <= PTR_W'(nk_of(req_len));
      end else if (run_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        // j counts 0..Nk-1 alongside the pointer, avoiding a modulo on i
        if ({1'b0, j} == nk_cur - 4'd1) j <= 3'd0;
        else                            j <= j + 3'd1;
        if (j == 3'd0) rcon <= xtime(rcon);
        if (last)      valid_q <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NW; k++) begin : g_word
    if (k < 8) begin : g_key
      // Word k: loaded from the cipher key on accept, else written by expansion.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          w[k] <= '0;
        end else if (accept && (k < int'(nk_of(req_len)))) begin
          w[k] <= bus.key_in[255-32*k -: 32];
        end else if (run_en && (wr_ptr == PTR_W'(k))) begin
          w[k] <= new_word;
        end
      end
    end else begin : g_exp
      // Word k: only ever written by expansion.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          w[k] <= '0;
        end else if (run_en && (wr_ptr == PTR_W'(k))) begin
          w[k] <= new_word;
        end
      end
    end
  end

  assign idx = bus.rk_idx;

  // Round-key read; indices past Nr of the active length read as zero.
  always_comb begin
    bus.rk_data = '0;
    base        = PTR_W'({idx, 2'b00});
    if (int'(idx) <= int'(nr_of(cur_len))) begin
      bus.rk_data = {w[base], w[base + PTR_W'(1)], w[base + PTR_W'(2)], w[base + PTR_W'(3)]};
    end
  end

  assign bus.busy       = (state == ST_RUN);
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.keys_valid = valid_q;

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Bench for aes_key_schedule_seq: table of FIPS-197 round-key vectors fed
// through a scoreboard, plus hand-written illegal/ignored/abort/back-to-back
// sequences.
module tb_aes_key_schedule_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  aes_key_schedule_seq_if #(.RK_IDX_W(4)) bus ();

  aes_key_schedule_seq #(.MAX_KEY_BITS(256), .RK_IDX_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0]   len;
    logic [255:0] key;
    int           lat;
  } run_t;

  typedef struct {
    int           run;
    logic [3:0]   idx;
    logic [127:0] mask;
    logic [127:0] exp;
  } rk_vec_t;

  localparam logic [127:0] ALL = {128{1'b1}};
  localparam logic [127:0] LOW = 128'hffffffff;

  run_t    runs [3];
  rk_vec_t vecs [$];
  rk_vec_t exp_q [$];
  int      lat_q [$];
  int      checks = 0;
  int      errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a start for table entry r and push its expectations.
  task automatic launch(input int r);
    bus.key_len = runs[r].len;
    bus.key_in  = runs[r].key;
    bus.start   = 1'b1;
    lat_q.push_back(runs[r].lat);
    foreach (vecs[k]) if (vecs[k].run == r) exp_q.push_back(vecs[k]);
  endtask

  // Count cycles until done (bounded); optionally pulse a start while busy.
  task automatic wait_done(input int inject_at, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
      if (cyc == 1) begin
        bus.start = 1'b0;
        check("busy_after_start", 128'(bus.busy), 128'd1);
        check("kv_low_while_busy", 128'(bus.keys_valid), 128'd0);
        check("done_low_first_cycle", 128'(bus.done), 128'd0);
      end
      if (cyc == inject_at) begin
        bus.start   = 1'b1;
        bus.key_len = 2'b00;
        bus.key_in  = {8{32'hdeadbeef}};
      end else if (cyc == inject_at + 1) begin
        bus.start = 1'b0;
      end
    end while (!bus.done && cyc < 200);
  endtask

  // Pop the scoreboard for the run that just signalled done.
  task automatic check_run(input string tag, input int cyc);
    int      lat;
    rk_vec_t v;
    lat = (lat_q.size() > 0) ? lat_q.pop_front() : -1;
    check({tag, "_latency"}, 128'(cyc), 128'(lat));
    check({tag, "_idle_at_done"}, 128'(bus.busy), 128'd0);
    check({tag, "_keys_valid"}, 128'(bus.keys_valid), 128'd1);
    while (exp_q.size() > 0) begin
      v = exp_q.pop_front();
      bus.rk_idx = v.idx;
      #1;
      check($sformatf("%s_rk%0d", tag, v.idx), bus.rk_data & v.mask, v.exp & v.mask);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   cyc;
    logic seen;

    runs[0] = '{2'b00, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 41};
    runs[1] = '{2'b01, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0}, 47};
    runs[2] = '{2'b10, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 53};

    vecs.push_back('{0, 4'd0,  ALL, 128'h2b7e151628aed2a6abf7158809cf4f3c});
    vecs.push_back('{0, 4'd1,  ALL, 128'ha0fafe1788542cb123a339392a6c7605});
    vecs.push_back('{0, 4'd9,  ALL, 128'hac7766f319fadc2128d12941575c006e});
    vecs.push_back('{0, 4'd10, ALL, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6});
    vecs.push_back('{0, 4'd11, ALL, 128'h0});
    vecs.push_back('{1, 4'd0,  ALL, 128'h8e73b0f7da0e6452c810f32b809079e5});
    vecs.push_back('{1, 4'd1,  ALL, 128'h62f8ead2522c6b7bfe0c91f72402f5a5});
    vecs.push_back('{1, 4'd12, LOW, 128'h01002202});
    vecs.push_back('{1, 4'd13, ALL, 128'h0});
    vecs.push_back('{2, 4'd0,  ALL, 128'h603deb1015ca71be2b73aef0857d7781});
    vecs.push_back('{2, 4'd2,  ALL, 128'h9ba354118e6925afa51a8b5f2067fcde});
    vecs.push_back('{2, 4'd3,  ALL, 128'ha8b09c1a93d194cdbe49846eb75d5b9a});
    vecs.push_back('{2, 4'd14, LOW, 128'h706c631e});
    vecs.push_back('{2, 4'd15, ALL, 128'h0});

    bus.start   = 1'b0;
    bus.key_len = 2'b00;
    bus.key_in  = '0;
    bus.rk_idx  = 4'd10;
    rst_n       = 1'b0;
    repeat (3) tick();
    check("rst_busy", 128'(bus.busy), 128'd0);
    check("rst_done", 128'(bus.done), 128'd0);
    check("rst_err", 128'(bus.err), 128'd0);
    check("rst_keys_valid", 128'(bus.keys_valid), 128'd0);
    check("rst_rk_data", bus.rk_data, 128'h0);
    rst_n = 1'b1;
    tick();

    // Table-driven runs for all three key lengths
    for (int r = 0; r < 3; r++) begin
      launch(r);
      wait_done(0, cyc);
      check_run($sformatf("run%0d", r), cyc);
      tick();
      check("done_single_cycle", 128'(bus.done), 128'd0);
    end

    // Illegal key_len after a valid AES-128 schedule
    launch(0);
    wait_done(0, cyc);
    check_run("aes128_pre_illegal", cyc);
    tick();
    bus.key_len = 2'b11;
    bus.key_in  = {8{32'h01234567}};
    bus.rk_idx  = 4'd10;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    check("illegal_err_pulse", 128'(bus.err), 128'd1);
    check("illegal_not_busy", 128'(bus.busy), 128'd0);
    check("illegal_kv_kept", 128'(bus.keys_valid), 128'd1);
    check("illegal_rk_kept", bus.rk_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    tick();
    check("illegal_err_ends", 128'(bus.err), 128'd0);
    check("illegal_rk_still", bus.rk_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Start pulsed mid-run is ignored; AES-192 timing and keys unchanged
    launch(1);
    wait_done(10, cyc);
    check_run("aes192_ignored_start", cyc);
    check("ignored_no_err", 128'(bus.err), 128'd0);
    tick();

    // Reset at cycle 20 of an AES-256 run aborts it
    launch(2);
    for (int c = 0; c < 20; c++) begin
      tick();
      if (c == 0) bus.start = 1'b0;
    end
    rst_n      = 1'b0;
    bus.rk_idx = 4'd0;
    tick();
    exp_q.delete();
    lat_q.delete();
    check("abort_busy", 128'(bus.busy), 128'd0);
    check("abort_keys_valid", 128'(bus.keys_valid), 128'd0);
    check("abort_done", 128'(bus.done), 128'd0);
    check("abort_rk_data", bus.rk_data, 128'h0);
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (60) begin
      tick();
      if (bus.done) seen = 1'b1;
    end
    check("abort_no_done", 128'(seen), 128'd0);
    launch(0);
    wait_done(0, cyc);
    check_run("aes128_after_abort", cyc);

    // Back-to-back: AES-256 start issued in the AES-128 done cycle
    launch(2);
    wait_done(0, cyc);
    check_run("aes256_back_to_back", cyc);
    tick();
    check("final_done_low", 128'(bus.done), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
